// File: rtl/singlecycle_pkg.sv
// Shared types for the decode stage: ALU/operand selects, RV32I opcodes,
// the decoded bundle carried from decode to execute, and the funct3 ALU map.
package singlecycle_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } ALUSel_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } OpASel_e;

    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } OpBSel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Everything execute needs from one instruction; all-zero is the reset/NOP value.
    typedef struct packed {
        ALUSel_e     alu_op;
        OpASel_e     opa_sel;
        OpBSel_e     opb_sel;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_wren;
        logic [31:0] pc;
        logic        illegal;
    } id_bundle_t;

    // funct3 to ALU op; alt selects SUB/SRA in the 000/101 slots.
    function automatic ALUSel_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        ALUSel_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and execute-side handshake/bus of the decode stage.
// Handshake rule on both sides: a transfer happens on a rising clock edge
// where valid and ready are both high; while valid is high and ready is low
// the producer holds valid and payload unchanged.
interface id_stage_if;
    import singlecycle_pkg::*;

    logic        i_if_valid;
    logic        o_if_ready;
    logic [31:0] i_if_instr;
    logic [31:0] i_if_pc;
    logic        i_flush;
    logic        o_ex_valid;
    logic        i_ex_ready;
    ALUSel_e     o_ex_alu_op;
    OpASel_e     o_ex_opa_sel;
    OpBSel_e     o_ex_opb_sel;
    logic [31:0] o_ex_imm;
    logic [4:0]  o_ex_rs1_addr;
    logic [4:0]  o_ex_rs2_addr;
    logic [4:0]  o_ex_rd_addr;
    logic        o_ex_rd_wren;
    logic [31:0] o_ex_pc;
    logic        o_ex_illegal;

    // Environment side: fetch producer and execute consumer.
    modport master (
        output i_if_valid, i_if_instr, i_if_pc, i_flush, i_ex_ready,
        input  o_if_ready, o_ex_valid, o_ex_alu_op, o_ex_opa_sel, o_ex_opb_sel,
               o_ex_imm, o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd_addr,
               o_ex_rd_wren, o_ex_pc, o_ex_illegal
    );

    // Decode stage side.
    modport slave (
        input  i_if_valid, i_if_instr, i_if_pc, i_flush, i_ex_ready,
        output o_if_ready, o_ex_valid, o_ex_alu_op, o_ex_opa_sel, o_ex_opb_sel,
               o_ex_imm, o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd_addr,
               o_ex_rd_wren, o_ex_pc, o_ex_illegal
    );
endinterface

// File: rtl/id_decoder.sv
// Purely combinational RV32I decoder producing one id_bundle_t per word.
module id_decoder
    import singlecycle_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output id_bundle_t  bundle
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    ALUSel_e     alu_op;
    OpASel_e     opa_sel;
    OpBSel_e     opb_sel;
    logic [31:0] imm;
    logic        wren;
    logic        illegal;

    // Opcode-driven field selection; unsupported encodings become a NOP (ADD, no writeback).
    always_comb begin
        alu_op  = ALU_ADD;
        opa_sel = OPA_RS1;
        opb_sel = OPB_RS2;
        imm     = 32'd0;
        wren    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    alu_op = alu_from_funct3(funct3, funct7[5]);
                    wren   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                opb_sel = OPB_IMM;
                imm     = imm_i;
                if (funct3 == 3'b001) begin
                    // SLLI only exists with a zero upper shamt field
                    if (funct7 == F7_BASE) begin
                        alu_op = ALU_SLL;
                        wren   = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                        alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        wren   = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    // imm bit 30 is immediate data here, never a SUB select
                    alu_op = alu_from_funct3(funct3, 1'b0);
                    wren   = 1'b1;
                end
            end
            OPC_LUI: begin
                opa_sel = OPA_ZERO;
                opb_sel = OPB_IMM;
                imm     = imm_u;
                wren    = 1'b1;
            end
            OPC_AUIPC: begin
                opa_sel = OPA_PC;
                opb_sel = OPB_IMM;
                imm     = imm_u;
                wren    = 1'b1;
            end
            OPC_LOAD: begin
                opb_sel = OPB_IMM;
                imm     = imm_i;
                wren    = 1'b1;
            end
            OPC_STORE: begin
                opb_sel = OPB_IMM;
                imm     = imm_s;
            end
            OPC_BRANCH: begin
                opa_sel = OPA_PC;
                opb_sel = OPB_IMM;
                imm     = imm_b;
            end
            OPC_JAL: begin
                opa_sel = OPA_PC;
                opb_sel = OPB_IMM;
                imm     = imm_j;
                wren    = 1'b1;
            end
            OPC_JALR: begin
                opb_sel = OPB_IMM;
                imm     = imm_i;
                wren    = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Pack the bundle; x0 is never written back.
    always_comb begin
        bundle          = '0;
        bundle.alu_op   = alu_op;
        bundle.opa_sel  = opa_sel;
        bundle.opb_sel  = opb_sel;
        bundle.imm      = imm;
        bundle.rs1_addr = instr[19:15];
        bundle.rs2_addr = instr[24:20];
        bundle.rd_addr  = instr[11:7];
        bundle.rd_wren  = wren & (instr[11:7] != 5'd0);
        bundle.pc       = pc;
        bundle.illegal  = illegal & ILLEGAL_TRAP;
    end

endmodule

// File: rtl/id_stage.sv
// Decode pipeline stage: decoder in front of an output register plus one
// skid entry, so fetch sees a registered ready and no bundle is lost when
// execute stalls.
module id_stage
    import singlecycle_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic    i_clk,
    input  logic    i_rst,
    id_stage_if.slave bus
);
    id_bundle_t dec_bundle;

    id_decoder #(
        .ILLEGAL_TRAP(ILLEGAL_TRAP)
    ) u_decoder (
        .instr (bus.i_if_instr),
        .pc    (bus.i_if_pc),
        .bundle(dec_bundle)
    );

    logic       out_valid_q, out_valid_n;
    id_bundle_t out_q, out_n;
    logic       skid_valid_q, skid_valid_n;
    id_bundle_t skid_q, skid_n;
    logic       if_ready_q, if_ready_n;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = bus.i_if_valid & if_ready_q;
    assign out_xfer = out_valid_q & bus.i_ex_ready;

    // Next-state of output/skid entries. Skid is only filled while output is stalled,
    // and fetch is held off whenever skid is full, so skid refill and input never collide.
    always_comb begin
        out_valid_n  = out_valid_q;
        out_n        = out_q;
        skid_valid_n = skid_valid_q;
        skid_n       = skid_q;
        if (bus.i_flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!out_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                out_valid_n  = 1'b1;
                out_n        = skid_q;
                skid_valid_n = 1'b0;
            end else if (in_xfer) begin
                out_valid_n = 1'b1;
                out_n       = dec_bundle;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_n = 1'b1;
            skid_n       = dec_bundle;
        end
        if_ready_n = ~skid_valid_n;
    end

    // Stage registers; reset empties both entries and holds fetch off.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            if_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_n;
            out_q        <= out_n;
            skid_valid_q <= skid_valid_n;
            skid_q       <= skid_n;
            if_ready_q   <= if_ready_n;
        end
    end

    // Drive the bus straight from the registers.
    always_comb begin
        bus.o_if_ready    = if_ready_q;
        bus.o_ex_valid    = out_valid_q;
        bus.o_ex_alu_op   = out_q.alu_op;
        bus.o_ex_opa_sel  = out_q.opa_sel;
        bus.o_ex_opb_sel  = out_q.opb_sel;
        bus.o_ex_imm      = out_q.imm;
        bus.o_ex_rs1_addr = out_q.rs1_addr;
        bus.o_ex_rs2_addr = out_q.rs2_addr;
        bus.o_ex_rd_addr  = out_q.rd_addr;
        bus.o_ex_rd_wren  = out_q.rd_wren;
        bus.o_ex_pc       = out_q.pc;
        bus.o_ex_illegal  = out_q.illegal;
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vectors, stall/skid ordering, flush,
// asynchronous reset mid-stall, and the ILLEGAL_TRAP=0 variant.
module tb_id_stage;
    import singlecycle_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    id_stage_if bus();
    id_stage_if bus_nt();

    id_stage #(.ILLEGAL_TRAP(1'b1)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    id_stage #(.ILLEGAL_TRAP(1'b0)) dut_nt (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus_nt)
    );

    assign bus_nt.i_if_valid = bus.i_if_valid;
    assign bus_nt.i_if_instr = bus.i_if_instr;
    assign bus_nt.i_if_pc    = bus.i_if_pc;
    assign bus_nt.i_flush    = bus.i_flush;
    assign bus_nt.i_ex_ready = bus.i_ex_ready;

    // clock / reset
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.i_if_valid = v;
        bus.i_if_instr = instr;
        bus.i_if_pc    = pc;
    endtask

    // scoreboard: every output transfer must match the next expected PC
    always @(negedge i_clk) begin
        if (bus.o_ex_valid && bus.i_ex_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL deliver_unexpected observed pc=%h expected=no delivery", bus.o_ex_pc);
            end
            if (exp_q.size() != 0) chk("deliver_order", bus.o_ex_pc, exp_q.pop_front());
        end
    end

    initial begin
        i_rst          = 1'b1;
        bus.i_flush    = 1'b0;
        bus.i_ex_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        tick();

        // reset values
        chk("rst_ex_valid", 32'(bus.o_ex_valid), 32'd0);
        chk("rst_if_ready", 32'(bus.o_if_ready), 32'd0);
        chk("rst_alu_op",   32'(bus.o_ex_alu_op), 32'(ALU_ADD));
        chk("rst_imm",      bus.o_ex_imm, 32'd0);
        chk("rst_pc",       bus.o_ex_pc, 32'd0);
        chk("rst_rd_wren",  32'(bus.o_ex_rd_wren), 32'd0);
        chk("rst_illegal",  32'(bus.o_ex_illegal), 32'd0);

        i_rst = 1'b0;
        tick();
        chk("rel_if_ready", 32'(bus.o_if_ready), 32'd1);
        chk("rel_ex_valid", 32'(bus.o_ex_valid), 32'd0);

        // back-to-back decode vectors, execute always ready
        bus.i_ex_ready = 1'b1;
        drive(1'b1, 32'h40B50533, 32'h100); exp_q.push_back(32'h100);
        tick();
        chk("sub_valid", 32'(bus.o_ex_valid), 32'd1);
        chk("sub_alu",   32'(bus.o_ex_alu_op), 32'(ALU_SUB));
        chk("sub_rs1",   32'(bus.o_ex_rs1_addr), 32'd10);
        chk("sub_rs2",   32'(bus.o_ex_rs2_addr), 32'd11);
        chk("sub_rd",    32'(bus.o_ex_rd_addr), 32'd10);
        chk("sub_wren",  32'(bus.o_ex_rd_wren), 32'd1);
        chk("sub_opb",   32'(bus.o_ex_opb_sel), 32'(OPB_RS2));
        chk("sub_pc",    bus.o_ex_pc, 32'h100);

        drive(1'b1, 32'h40335293, 32'h104); exp_q.push_back(32'h104);
        tick();
        chk("srai_alu",  32'(bus.o_ex_alu_op), 32'(ALU_SRA));
        chk("srai_opb",  32'(bus.o_ex_opb_sel), 32'(OPB_IMM));
        chk("srai_imm",  bus.o_ex_imm, 32'h00000403);
        chk("srai_rd",   32'(bus.o_ex_rd_addr), 32'd5);
        chk("srai_rs1",  32'(bus.o_ex_rs1_addr), 32'd6);

        drive(1'b1, 32'h123450B7, 32'h108); exp_q.push_back(32'h108);
        tick();
        chk("lui_alu",   32'(bus.o_ex_alu_op), 32'(ALU_ADD));
        chk("lui_opa",   32'(bus.o_ex_opa_sel), 32'(OPA_ZERO));
        chk("lui_imm",   bus.o_ex_imm, 32'h12345000);
        chk("lui_rd",    32'(bus.o_ex_rd_addr), 32'd1);
        chk("lui_wren",  32'(bus.o_ex_rd_wren), 32'd1);

        drive(1'b1, 32'hFFFFFFFF, 32'h10C); exp_q.push_back(32'h10C);
        tick();
        chk("ill_flag",    32'(bus.o_ex_illegal), 32'd1);
        chk("ill_wren",    32'(bus.o_ex_rd_wren), 32'd0);
        chk("ill_alu",     32'(bus.o_ex_alu_op), 32'(ALU_ADD));
        chk("ill_nt_valid", 32'(bus_nt.o_ex_valid), 32'd1);
        chk("ill_nt_flag", 32'(bus_nt.o_ex_illegal), 32'd0);
        chk("ill_nt_wren", 32'(bus_nt.o_ex_rd_wren), 32'd0);

        drive(1'b1, 32'h00000033, 32'h110); exp_q.push_back(32'h110);
        tick();
        chk("x0_wren",    32'(bus.o_ex_rd_wren), 32'd0);
        chk("x0_illegal", 32'(bus.o_ex_illegal), 32'd0);

        drive(1'b1, 32'h00208463, 32'h114); exp_q.push_back(32'h114);
        tick();
        chk("beq_opa",  32'(bus.o_ex_opa_sel), 32'(OPA_PC));
        chk("beq_imm",  bus.o_ex_imm, 32'h00000008);
        chk("beq_wren", 32'(bus.o_ex_rd_wren), 32'd0);

        drive(1'b1, 32'hFE512E23, 32'h118); exp_q.push_back(32'h118);
        tick();
        chk("sw_imm",  bus.o_ex_imm, 32'hFFFFFFFC);
        chk("sw_rs2",  32'(bus.o_ex_rs2_addr), 32'd5);
        chk("sw_wren", 32'(bus.o_ex_rd_wren), 32'd0);

        drive(1'b1, 32'h010000EF, 32'h11C); exp_q.push_back(32'h11C);
        tick();
        chk("jal_opa",  32'(bus.o_ex_opa_sel), 32'(OPA_PC));
        chk("jal_imm",  bus.o_ex_imm, 32'h00000010);
        chk("jal_wren", 32'(bus.o_ex_rd_wren), 32'd1);

        drive(1'b0, 32'd0, 32'd0);
        tick();
        chk("idle_ex_valid", 32'(bus.o_ex_valid), 32'd0);

        // stall: two instructions into output + skid, held for 3 cycles
        bus.i_ex_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h200); exp_q.push_back(32'h200);
        tick();
        chk("stall_a_valid",  32'(bus.o_ex_valid), 32'd1);
        chk("stall_ready_1",  32'(bus.o_if_ready), 32'd1);
        drive(1'b1, 32'h0020C233, 32'h204); exp_q.push_back(32'h204);
        tick();
        chk("stall_ready_0",  32'(bus.o_if_ready), 32'd0);
        chk("stall_a_pc",     bus.o_ex_pc, 32'h200);
        chk("stall_a_rd",     32'(bus.o_ex_rd_addr), 32'd3);
        drive(1'b0, 32'd0, 32'd0);
        tick();
        chk("stall_hold_pc",  bus.o_ex_pc, 32'h200);
        chk("stall_hold_alu", 32'(bus.o_ex_alu_op), 32'(ALU_ADD));
        chk("stall_hold_rdy", 32'(bus.o_if_ready), 32'd0);
        bus.i_ex_ready = 1'b1;
        tick();
        chk("stall_b_pc",     bus.o_ex_pc, 32'h204);
        chk("stall_b_alu",    32'(bus.o_ex_alu_op), 32'(ALU_XOR));
        chk("stall_b_rd",     32'(bus.o_ex_rd_addr), 32'd4);
        chk("stall_b_ready",  32'(bus.o_if_ready), 32'd1);
        tick();
        chk("stall_drained",  32'(bus.o_ex_valid), 32'd0);

        // flush with both entries full and fetch still presenting
        bus.i_ex_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h300);
        tick();
        drive(1'b1, 32'h0020C233, 32'h304);
        tick();
        chk("fl1_full_ready", 32'(bus.o_if_ready), 32'd0);
        drive(1'b1, 32'h40B50533, 32'h308);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("fl1_ex_valid", 32'(bus.o_ex_valid), 32'd0);
        chk("fl1_if_ready", 32'(bus.o_if_ready), 32'd1);
        bus.i_ex_ready = 1'b1;
        tick();
        chk("fl1_no_stale", 32'(bus.o_ex_valid), 32'd0);

        // flush racing an accepted input
        bus.i_ex_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h310);
        tick();
        chk("fl2_pre_ready", 32'(bus.o_if_ready), 32'd1);
        drive(1'b1, 32'h0020C233, 32'h314);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("fl2_ex_valid", 32'(bus.o_ex_valid), 32'd0);
        chk("fl2_if_ready", 32'(bus.o_if_ready), 32'd1);
        bus.i_ex_ready = 1'b1;
        tick();
        chk("fl2_no_stale", 32'(bus.o_ex_valid), 32'd0);

        // asynchronous reset mid-stall
        bus.i_ex_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h400);
        tick();
        drive(1'b1, 32'h0020C233, 32'h404);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        chk("mr_pre_valid", 32'(bus.o_ex_valid), 32'd1);
        chk("mr_pre_ready", 32'(bus.o_if_ready), 32'd0);
        #2;
        i_rst = 1'b1;
        #1;
        chk("mr_async_valid", 32'(bus.o_ex_valid), 32'd0);
        chk("mr_async_ready", 32'(bus.o_if_ready), 32'd0);
        chk("mr_async_pc",    bus.o_ex_pc, 32'd0);
        bus.i_ex_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        chk("mr_post_valid", 32'(bus.o_ex_valid), 32'd0);
        chk("mr_post_ready", 32'(bus.o_if_ready), 32'd1);
        tick();
        chk("mr_quiet", 32'(bus.o_ex_valid), 32'd0);

        // fresh instruction after reset flows normally
        drive(1'b1, 32'h40B50533, 32'h500); exp_q.push_back(32'h500);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        chk("post_valid", 32'(bus.o_ex_valid), 32'd1);
        chk("post_pc",    bus.o_ex_pc, 32'h500);
        tick();
        chk("post_idle",  32'(bus.o_ex_valid), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
